// File: rtl/cf_sweep_ctrl.sv
// Exhaustive input sweeper for a combinational CF_* function unit: builds truth table and minterm count.
// Optional self-check against an expected table when CF_SWEEP_CHECK_EN is defined.
module cf_sweep_ctrl #(
   parameter int NVARS  = 5,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  y_i,
`ifdef CF_SWEEP_CHECK_EN
   input  logic [2**NVARS-1:0]   exp_tt_i,
   output logic                  match_o,
   output logic [NVARS-1:0]      first_err_o,
`endif
   output logic [NVARS-1:0]      vec_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [2**NVARS-1:0]   tt_o,
   output logic [NVARS:0]        ones_o
);

   localparam int NTT = 2**NVARS;
   localparam logic [3:0]       CNT_INIT = 4'(SETTLE - 1);
   localparam logic [NVARS-1:0] VEC_ONE  = NVARS'(1);
   localparam logic [NVARS-1:0] VEC_LAST = '1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

   state_t               r_state, w_nxt;
   logic [NVARS-1:0]     r_vec;
   logic [3:0]           r_cnt;
   logic [NTT-1:0]       r_tt, w_tt_nxt;
   logic [NVARS:0]       r_ones;
   logic                 w_accept, w_capture, w_last;
   logic                 w_busy, w_done;

   assign w_last = (r_vec == VEC_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nxt;
   end

   // Abort outranks both a pending start and a same-cycle capture.
   always_comb begin
      w_nxt     = r_state;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      w_busy    = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               w_accept = 1'b1;
               w_nxt    = S_SETTLE;
            end
         end
         S_SETTLE: begin
            w_busy = 1'b1;
            if (abort_i)            w_nxt = S_IDLE;
            else if (r_cnt == 4'd0) w_nxt = S_SAMPLE;
         end
         S_SAMPLE: begin
            w_busy = 1'b1;
            if (abort_i) w_nxt = S_IDLE;
            else begin
               w_capture = 1'b1;
               w_nxt     = w_last ? S_DONE : S_SETTLE;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_nxt  = S_IDLE;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_tt_nxt        = r_tt;
      w_tt_nxt[r_vec] = y_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vec  <= '0;
         r_cnt  <= '0;
         r_tt   <= '0;
         r_ones <= '0;
      end else if (w_accept) begin
         r_vec  <= '0;
         r_cnt  <= CNT_INIT;
         r_tt   <= '0;
         r_ones <= '0;
      end else if (w_busy && abort_i) begin
         r_vec <= '0;
         r_cnt <= '0;
      end else if (w_capture) begin
         r_tt   <= w_tt_nxt;
         r_ones <= r_ones + {{NVARS{1'b0}}, y_i};
         if (!w_last) begin
            r_vec <= r_vec + VEC_ONE;
            r_cnt <= CNT_INIT;
         end
      end else if (r_state == S_SETTLE && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

`ifdef CF_SWEEP_CHECK_EN
   logic [NTT-1:0]   r_exp, w_diff;
   logic [NVARS-1:0] w_ferr;
   logic             r_match;
   logic [NVARS-1:0] r_ferr;

   // Lowest differing index: scan down so the smallest set bit wins.
   always_comb begin
      w_diff = w_tt_nxt ^ r_exp;
      w_ferr = '0;
      for (int i = NTT - 1; i >= 0; i--)
         if (w_diff[i]) w_ferr = NVARS'(i);
   end

   // Verdict is registered on the final capture so it is already valid in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exp   <= '0;
         r_match <= 1'b0;
         r_ferr  <= '0;
      end else if (w_accept) begin
         r_exp   <= exp_tt_i;
         r_match <= 1'b0;
         r_ferr  <= '0;
      end else if (w_capture && w_last) begin
         r_match <= (w_diff == '0);
         r_ferr  <= w_ferr;
      end
   end

   assign match_o     = r_match;
   assign first_err_o = r_ferr;
`endif

   assign vec_o  = r_vec;
   assign busy_o = w_busy;
   assign done_o = w_done;
   assign tt_o   = r_tt;
   assign ones_o = r_ones;

endmodule

// File: tb/tb_cf_sweep_ctrl.sv
// Directed bench for cf_sweep_ctrl: one instance with SETTLE=1, one with SETTLE=3.
module tb_cf_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        s1, a1, s3, a3;
   logic        ymode1, glitch3;
   logic [1:0]  ph3;
   logic [4:0]  vec1, vec3;
   logic        busy1, busy3, done1, done3;
   logic [31:0] tt1, tt3;
   logic [5:0]  ones1, ones3;
   logic        y1, y3;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   // Reference function: y = (~d&~e) | a | (~b&~c), a = MSB.
   function automatic logic fref(input logic [4:0] v);
      return (~v[1] & ~v[0]) | v[4] | (~v[3] & ~v[2]);
   endfunction

   assign y1 = ymode1 ? 1'b1 : fref(vec1);
   assign y3 = glitch3 ? ((ph3 == 2'd3) ? fref(vec3) : ph3[0]) : fref(vec3);

   // Phase within each 4-cycle vector of u3; phase 3 is the SAMPLE cycle.
   always @(posedge clk) begin
      if (!busy3) ph3 <= 2'd0;
      else        ph3 <= ph3 + 2'd1;
   end

`ifdef CF_SWEEP_CHECK_EN
   logic [31:0] exp1;
   logic [31:0] exp3 = 32'h0;
   logic        match1, match3;
   logic [4:0]  ferr1, ferr3;
`endif

   cf_sweep_ctrl #(.NVARS(5), .SETTLE(1)) u1 (
      .clk(clk), .rst(rst), .start_i(s1), .abort_i(a1), .y_i(y1),
`ifdef CF_SWEEP_CHECK_EN
      .exp_tt_i(exp1), .match_o(match1), .first_err_o(ferr1),
`endif
      .vec_o(vec1), .busy_o(busy1), .done_o(done1), .tt_o(tt1), .ones_o(ones1));

   cf_sweep_ctrl #(.NVARS(5), .SETTLE(3)) u3 (
      .clk(clk), .rst(rst), .start_i(s3), .abort_i(a3), .y_i(y3),
`ifdef CF_SWEEP_CHECK_EN
      .exp_tt_i(exp3), .match_o(match3), .first_err_o(ferr3),
`endif
      .vec_o(vec3), .busy_o(busy3), .done_o(done3), .tt_o(tt3), .ones_o(ones3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs a u1 sweep, returning in the DONE cycle (or after the budget).
   task automatic sweep1(input bit poke, output int nbusy, output int ndone);
      nbusy = 0;
      ndone = 0;
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (busy1) nbusy++;
         if (done1) begin
            ndone++;
            break;
         end
         s1 = (poke && (k == 20 || k == 41)) ? 1'b1 : 1'b0;
         tick();
      end
      s1 = 1'b0;
   endtask

   task automatic test_reset();
      int k;
      n_cmp++;
      if (vec1 !== 5'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || tt1 !== 32'h0 || ones1 !== 6'd0) begin
         n_err++;
         $display("FAIL reset_init: vec=%0d busy=%b done=%b tt=%h ones=%0d, want all 0", vec1, busy1, done1, tt1, ones1);
      end
      ymode1 = 1'b0;
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      for (k = 0; k < 100 && vec1 !== 5'd7; k++) tick();
      n_cmp++;
      if (vec1 !== 5'd7 || busy1 !== 1'b1) begin
         n_err++;
         $display("FAIL reset_reach7: vec=%0d busy=%b, want 7/1", vec1, busy1);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (vec1 !== 5'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || tt1 !== 32'h0 || ones1 !== 6'd0) begin
         n_err++;
         $display("FAIL reset_mid: vec=%0d busy=%b done=%b tt=%h ones=%0d, want all 0", vec1, busy1, done1, tt1, ones1);
      end
      tick();
      rst = 1'b0;
      tick();
      n_cmp++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_after: busy=%b done=%b, want 0/0", busy1, done1);
      end
   endtask

   task automatic test_sweep_settle1();
      int nb, nd;
      ymode1 = 1'b0;
      sweep1(1'b1, nb, nd);
      n_cmp++;
      if (nb !== 64 || nd !== 1) begin
         n_err++;
         $display("FAIL s1_timing: busy_cycles=%0d done=%0d, want 64/1", nb, nd);
      end
      n_cmp++;
      if (tt1 !== 32'hFFFF111F || ones1 !== 6'd23 || vec1 !== 5'd31) begin
         n_err++;
         $display("FAIL s1_result: tt=%h ones=%0d vec=%0d, want FFFF111F/23/31", tt1, ones1, vec1);
      end
   endtask

   task automatic test_back_to_back();
      // start in DONE must be ignored; done is a single-cycle pulse
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      n_cmp++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || tt1 !== 32'hFFFF111F || ones1 !== 6'd23) begin
         n_err++;
         $display("FAIL start_in_done: busy=%b done=%b tt=%h ones=%0d, want 0/0/FFFF111F/23", busy1, done1, tt1, ones1);
      end
      tick();
      n_cmp++;
      if (busy1 !== 1'b0 || vec1 !== 5'd31) begin
         n_err++;
         $display("FAIL idle_hold: busy=%b vec=%0d, want 0/31", busy1, vec1);
      end
   endtask

   task automatic sweep3(output int nbusy, output int nchg, output int nbad, output int ndone);
      logic [4:0] prev;
      int last;
      nbusy = 0; nchg = 0; nbad = 0; ndone = 0;
      prev = 5'd0;
      last = 0;
      s3 = 1'b1;
      tick();
      s3 = 1'b0;
      for (int k = 0; k < 600; k++) begin
         if (busy3) nbusy++;
         if (vec3 !== prev) begin
            nchg++;
            if (k - last != 4) nbad++;
            last = k;
            prev = vec3;
         end
         if (done3) begin
            ndone++;
            break;
         end
         tick();
      end
   endtask

   task automatic test_settle3();
      int nb, nc, nbad, nd;
      glitch3 = 1'b0;
      sweep3(nb, nc, nbad, nd);
      n_cmp++;
      if (nb !== 128 || nd !== 1) begin
         n_err++;
         $display("FAIL s3_timing: busy_cycles=%0d done=%0d, want 128/1", nb, nd);
      end
      n_cmp++;
      if (nc !== 31 || nbad !== 0) begin
         n_err++;
         $display("FAIL s3_vec_step: changes=%0d bad_intervals=%0d, want 31/0", nc, nbad);
      end
      n_cmp++;
      if (tt3 !== 32'hFFFF111F || ones3 !== 6'd23) begin
         n_err++;
         $display("FAIL s3_result: tt=%h ones=%0d, want FFFF111F/23", tt3, ones3);
      end
      tick();
   endtask

   task automatic test_glitch();
      int nb, nc, nbad, nd;
      glitch3 = 1'b1;
      sweep3(nb, nc, nbad, nd);
      glitch3 = 1'b0;
      n_cmp++;
      if (nd !== 1 || tt3 !== 32'hFFFF111F || ones3 !== 6'd23) begin
         n_err++;
         $display("FAIL glitch: done=%0d tt=%h ones=%0d, want 1/FFFF111F/23", nd, tt3, ones3);
      end
      tick();
   endtask

   task automatic test_abort();
      bit saw_done;
      ymode1 = 1'b1;
      s1 = 1'b1;
      tick();
      s1 = 1'b0;
      repeat (21) tick();
      n_cmp++;
      if (vec1 !== 5'd10 || busy1 !== 1'b1) begin
         n_err++;
         $display("FAIL abort_pos: vec=%0d busy=%b, want 10/1", vec1, busy1);
      end
      a1 = 1'b1;
      tick();
      a1 = 1'b0;
      n_cmp++;
      if (busy1 !== 1'b0 || vec1 !== 5'd0 || done1 !== 1'b0 || tt1 !== 32'h000003FF || ones1 !== 6'd10) begin
         n_err++;
         $display("FAIL abort: busy=%b vec=%0d done=%b tt=%h ones=%0d, want 0/0/0/000003FF/10", busy1, vec1, done1, tt1, ones1);
      end
      saw_done = 1'b0;
      repeat (4) begin
         tick();
         if (done1 || busy1) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin
         n_err++;
         $display("FAIL abort_quiet: activity after abort=%b, want 0", saw_done);
      end
      s1 = 1'b1;
      a1 = 1'b1;
      tick();
      s1 = 1'b0;
      a1 = 1'b0;
      n_cmp++;
      if (busy1 !== 1'b0 || tt1 !== 32'h000003FF || ones1 !== 6'd10) begin
         n_err++;
         $display("FAIL start_abort_idle: busy=%b tt=%h ones=%0d, want 0/000003FF/10", busy1, tt1, ones1);
      end
      ymode1 = 1'b0;
   endtask

`ifdef CF_SWEEP_CHECK_EN
   task automatic test_check();
      int nb, nd;
      n_cmp++;
      if (match1 !== 1'b0 || ferr1 !== 5'd0) begin
         n_err++;
         $display("FAIL chk_idle: match=%b ferr=%0d, want 0/0", match1, ferr1);
      end
      exp1 = 32'hFFFF111F;
      sweep1(1'b0, nb, nd);
      exp1 = 32'h0;
      n_cmp++;
      if (nd !== 1 || match1 !== 1'b1 || ferr1 !== 5'd0) begin
         n_err++;
         $display("FAIL chk_match: done=%0d match=%b ferr=%0d, want 1/1/0", nd, match1, ferr1);
      end
      tick();
      exp1 = 32'hFFFF101F;
      sweep1(1'b0, nb, nd);
      n_cmp++;
      if (nd !== 1 || match1 !== 1'b0 || ferr1 !== 5'd8) begin
         n_err++;
         $display("FAIL chk_mismatch: done=%0d match=%b ferr=%0d, want 1/0/8", nd, match1, ferr1);
      end
      tick();
   endtask
`endif

   initial begin
      rst = 1'b1;
      s1 = 1'b0; a1 = 1'b0; s3 = 1'b0; a3 = 1'b0;
      ymode1 = 1'b0; glitch3 = 1'b0;
`ifdef CF_SWEEP_CHECK_EN
      exp1 = 32'h0;
`endif
      tick();
      tick();
      rst = 1'b0;
      tick();
      test_reset();
      test_sweep_settle1();
      test_back_to_back();
      test_settle3();
      test_glitch();
      test_abort();
`ifdef CF_SWEEP_CHECK_EN
      test_check();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
